pkt_tag_buffer: RTL and testbench
=================================

PKT_TAG_BUFFER -- requirements
Module: pkt_tag_buffer

Interface
REQ-001 Parameter BUF_DEPTH, default 256, meaning bytes per bank (power of two).
REQ-002 clk  input  1  sole clock; all logic on posedge.
REQ-003 rst  input  1  reset, synchronous and active-high (asserted level `RST_ENABLED).
REQ-004 in_valid  input  1  ingress byte valid.
REQ-005 in_ready  output  1  ingress byte accepted when in_valid && in_ready.
REQ-006 in_data  input  8  ingress packet byte, wire order.
REQ-007 in_last  input  1  final byte of packet, qualified by in_valid.
REQ-008 tag_addr_i  input  `ADDR_WIDTH  parser byte offset into current packet.
REQ-009 tag_data  output  `DATA_WIDTH  bytes at offsets addr..addr+3, big-endian, byte addr in [31:24].
REQ-010 pkt_ready  output  1  complete packet available to parser.
REQ-011 pkt_len  output  16  byte length of packet presented to parser.
REQ-012 pkt_done  input  1  parser release of current packet.
REQ-013 err_trunc  output  1  one-cycle pulse when a packet exceeded BUF_DEPTH.

Function
REQ-014 Storage SHALL be two banks (ping-pong), each BUF_DEPTH bytes plus a length register and full flag.
REQ-015 Write side SHALL hold wr_bank and wr_ptr; in_ready = !full[wr_bank] and 0 while rst asserted.
REQ-016 Accepted byte SHALL be written at wr_ptr of wr_bank, then wr_ptr increments.
REQ-017 Accepted byte with in_last SHALL set len[wr_bank] = bytes stored, set full[wr_bank], toggle wr_bank, clear wr_ptr, same edge.
REQ-018 Bytes accepted after wr_ptr reaches BUF_DEPTH SHALL be consumed and discarded; len = BUF_DEPTH; err_trunc pulses on the cycle after in_last is accepted.
REQ-019 Read side SHALL hold rd_bank; pkt_ready = full[rd_bank]; pkt_len = len[rd_bank] when pkt_ready, else 0.
REQ-020 tag_data SHALL be registered: value for tag_addr_i at edge N valid after edge N (1-cycle latency), no alignment restriction on tag_addr_i.
REQ-021 Each byte lane of tag_data SHALL read 0 if its offset >= pkt_len, >= BUF_DEPTH, or pkt_ready = 0; no wrap-around into low offsets.
REQ-022 pkt_done with pkt_ready = 1 SHALL clear full[rd_bank] and toggle rd_bank on that edge; pkt_done with pkt_ready = 0 SHALL be ignored.
REQ-023 Write completion and pkt_done in the same cycle SHALL both take effect; in_ready reflects updated flags next cycle.
REQ-024 Both banks full SHALL hold in_ready = 0 until pkt_done; no byte lost or overwritten.
REQ-025 A one-byte packet (in_last on first byte) SHALL yield pkt_len = 1.
REQ-026 Packets SHALL be presented strictly in arrival order.

Reset
REQ-027 On rst: full flags 0, wr_bank = rd_bank = 0, wr_ptr = 0, tag_data = `ZERO_WORD, pkt_ready = 0, pkt_len = 0, err_trunc = 0.
REQ-028 Reset mid-packet or mid-parse SHALL discard all buffered data; first byte after reset starts a new packet in bank 0.
REQ-029 Bank byte contents need not be cleared; REQ-021 masking guarantees no stale data visible.

Structure
REQ-030 BUF_DEPTH default, BUF_ADDR_WIDTH, byte width, and bank-state encoding SHALL live in shared def.v alongside `DATA_WIDTH/`ADDR_WIDTH.
REQ-031 One sub-module pkt_bank SHALL implement a single bank: byte write port, 4-lane unaligned registered read port (lane = offset[1:0] interleave), length masking.

Verification
REQ-032 Send 60-byte frame with bytes 12..13 = 08 00; read addr 12 -> tag_data[31:16] = 16'h0800, pkt_len = 60, pkt_ready = 1.
REQ-033 Read addr 58 of same 60-byte frame -> tag_data = {b58, b59, 8'h00, 8'h00}; addr 300 -> 32'h0.
REQ-034 Send three 20-byte packets back-to-back with no pkt_done -> in_ready drops after second in_last; pkt_done releases bank, third packet accepted, order preserved.
REQ-035 Send 300-byte packet, BUF_DEPTH = 256 -> pkt_len = 256, err_trunc one pulse, next packet unaffected.
REQ-036 Assert rst after 10 bytes of a packet -> pkt_ready = 0, in_ready = 1 one cycle after release, following 14-byte packet gives pkt_len = 14 in bank 0.
REQ-037 pkt_done same cycle as in_last of other bank -> next cycle pkt_ready = 1 with new packet's length; pkt_done while pkt_ready = 0 -> no state change.

Source files
------------

// File: rtl/pkt_tag_buffer_pkg.sv
// ---------------------------------------------------------------------------
// pkt_tag_buffer_pkg
// Shared constants and types for the ping-pong packet tag buffer:
//   DATA_WIDTH / ADDR_WIDTH  width of the parser word and parser byte offset
//   BYTE_WIDTH / LEN_WIDTH   ingress byte width and packet length width
//   BUF_DEPTH_DEFAULT        bytes per bank (power of two, >= 8)
//   BUF_ADDR_WIDTH           byte address width of one default-sized bank
//   bank_state_e             occupancy encoding of a bank
// ---------------------------------------------------------------------------
package pkt_tag_buffer_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int ADDR_WIDTH        = 16;
    localparam int BYTE_WIDTH        = 8;
    localparam int LEN_WIDTH         = 16;
    localparam int BUF_DEPTH_DEFAULT = 256;
    localparam int BUF_ADDR_WIDTH    = $clog2(BUF_DEPTH_DEFAULT);

    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_e;

    // Byte address width of a bank holding 'depth' bytes.
    function automatic int buf_addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pkt_bank.sv
// ---------------------------------------------------------------------------
// pkt_bank
// One bank of the ping-pong buffer. Bytes are interleaved over four lane
// memories by offset[1:0], so any four consecutive offsets hit four
// different lanes and an unaligned 32-bit word is read in one cycle.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_wr_en          write the byte i_wr_data at byte offset i_wr_addr
//   i_rd_addr        parser byte offset (word = offsets addr..addr+3)
//   i_rd_len         stored packet length of this bank
//   i_rd_full        bank holds a complete packet
//   o_rd_data        registered big-endian word, invalid lanes read 0
// ---------------------------------------------------------------------------
module pkt_bank
    import pkt_tag_buffer_pkg::*;
#(
    parameter  int BUF_DEPTH = BUF_DEPTH_DEFAULT,
    localparam int BAW       = buf_addr_width(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [BAW-1:0]        i_wr_addr,
    input  logic [BYTE_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [LEN_WIDTH-1:0]  i_rd_len,
    input  logic                  i_rd_full,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int LANE_AW    = BAW - 2;
    localparam int LANE_DEPTH = BUF_DEPTH / 4;
    // One extra bit so addr+3 near the top of the offset range never wraps.
    localparam int OFF_W      = ADDR_WIDTH + 1;

    logic [BYTE_WIDTH-1:0] r_mem [4][LANE_DEPTH];
    logic [BYTE_WIDTH-1:0] r_lane [4];
    logic [1:0]            r_rot;
    logic [3:0]            r_byte_ok;

    logic [LANE_AW-1:0]    w_base_row;
    logic [LANE_AW-1:0]    w_row [4];
    logic [OFF_W-1:0]      w_off [4];
    logic [3:0]            w_byte_ok;

    // NOTE: the byte store has no reset; stale contents are never visible
    // because every lane is masked by the bank's length and full state.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr[1:0]][i_wr_addr[BAW-1:2]] <= i_wr_data;
        end
    end

    assign w_base_row = i_rd_addr[BAW-1:2];

    // Lanes below the start lane belong to the next row of the word.
    // Rows past the bank end wrap here, but those lanes are masked.
    // NOTE: every always_comb output gets a value on every pass, so no
    // latch can be inferred.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_row[k] = w_base_row + ((2'(k) < i_rd_addr[1:0]) ? LANE_AW'(1) : LANE_AW'(0));
        end
        for (int j = 0; j < 4; j++) begin
            w_off[j]     = {1'b0, i_rd_addr} + OFF_W'(j);
            w_byte_ok[j] = i_rd_full
                        && (w_off[j] < OFF_W'(i_rd_len))
                        && (w_off[j] < OFF_W'(BUF_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            r_lane[k] <= r_mem[k][w_row[k]];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rot     <= 2'd0;
            r_byte_ok <= 4'd0;
        end else begin
            r_rot     <= i_rd_addr[1:0];
            r_byte_ok <= w_byte_ok;
        end
    end

    // Output byte j (big-endian, j = 0 in [31:24]) lives in lane rot+j.
    always_comb begin
        o_rd_data = ZERO_WORD;
        for (int j = 0; j < 4; j++) begin
            if (r_byte_ok[j]) begin
                o_rd_data[DATA_WIDTH-1-BYTE_WIDTH*j -: BYTE_WIDTH] = r_lane[r_rot + 2'(j)];
            end
        end
    end

endmodule

// File: rtl/pkt_tag_buffer.sv
// ---------------------------------------------------------------------------
// pkt_tag_buffer
// Two-bank ping-pong packet buffer between a byte-stream ingress and a
// header parser. The write side fills one bank while the parser reads the
// other through an unaligned, registered 32-bit tag window.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     ingress byte valid        in_ready  ingress byte accepted
//   in_data      ingress byte              in_last   final byte of packet
//   tag_addr_i   parser byte offset        tag_data  bytes addr..addr+3, BE
//   pkt_ready    packet available          pkt_len   its length (0 if none)
//   pkt_done     parser releases packet    err_trunc packet exceeded bank
// ---------------------------------------------------------------------------
module pkt_tag_buffer
    import pkt_tag_buffer_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [ADDR_WIDTH-1:0] tag_addr_i,
    output logic [DATA_WIDTH-1:0] tag_data,
    output logic                  pkt_ready,
    output logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  pkt_done,
    output logic                  err_trunc
);

    localparam int BAW   = buf_addr_width(BUF_DEPTH);
    localparam int PTR_W = BAW + 1;

    bank_state_e          r_state [2];
    logic [LEN_WIDTH-1:0] r_len [2];
    logic                 r_wr_bank;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic                 r_rd_bank;
    logic                 r_sel;
    logic                 r_err_trunc;

    logic                  w_accept;
    logic                  w_ptr_at_end;
    logic                  w_store;
    logic                  w_release;
    logic [DATA_WIDTH-1:0] w_bank_data [2];

    assign in_ready     = !rst && (r_state[r_wr_bank] == BANK_EMPTY);
    assign pkt_ready    = (r_state[r_rd_bank] == BANK_FULL);
    assign pkt_len      = pkt_ready ? r_len[r_rd_bank] : '0;
    assign err_trunc    = r_err_trunc;

    assign w_accept     = in_valid && in_ready;
    // The pointer saturates at BUF_DEPTH; further bytes are consumed only.
    assign w_ptr_at_end = (r_wr_ptr == PTR_W'(BUF_DEPTH));
    assign w_store      = w_accept && !w_ptr_at_end;
    assign w_release    = pkt_done && pkt_ready;

    // Completion and release touch different banks: completion needs the
    // write bank empty, release needs the read bank full, so when both
    // fire together the banks differ.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0]  <= BANK_EMPTY;
            r_state[1]  <= BANK_EMPTY;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
            r_wr_bank   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_bank   <= 1'b0;
            r_sel       <= 1'b0;
            r_err_trunc <= 1'b0;
        end else begin
            r_err_trunc <= w_accept && in_last && w_ptr_at_end;
            if (w_accept) begin
                if (in_last) begin
                    r_len[r_wr_bank]   <= w_ptr_at_end ? LEN_WIDTH'(BUF_DEPTH)
                                                       : LEN_WIDTH'(r_wr_ptr) + LEN_WIDTH'(1);
                    r_state[r_wr_bank] <= BANK_FULL;
                    r_wr_bank          <= ~r_wr_bank;
                    r_wr_ptr           <= '0;
                end else if (!w_ptr_at_end) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
            end
            if (w_release) begin
                r_state[r_rd_bank] <= BANK_EMPTY;
                r_rd_bank          <= ~r_rd_bank;
            end
            // Remember which bank the tag word registered this edge came from.
            r_sel <= r_rd_bank;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pkt_bank #(
            .BUF_DEPTH (BUF_DEPTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_store && (r_wr_bank == 1'(g))),
            .i_wr_addr (r_wr_ptr[BAW-1:0]),
            .i_wr_data (in_data),
            .i_rd_addr (tag_addr_i),
            .i_rd_len  (r_len[g]),
            .i_rd_full (r_state[g] == BANK_FULL),
            .o_rd_data (w_bank_data[g])
        );
    end

    assign tag_data = r_sel ? w_bank_data[1] : w_bank_data[0];

endmodule

// File: tb/tb_pkt_tag_buffer.sv
// ---------------------------------------------------------------------------
// tb_pkt_tag_buffer
// Scoreboard bench for pkt_tag_buffer: each packet sent is pushed to a
// queue; when the DUT presents a packet the oldest entry is popped and its
// length and tag windows are compared against a byte-level model.
// ---------------------------------------------------------------------------
module tb_pkt_tag_buffer;
    import pkt_tag_buffer_pkg::*;

    localparam int DEPTH   = 256;
    localparam int MAX_PKT = 512;
    localparam int N_PKT   = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [BYTE_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [ADDR_WIDTH-1:0] tag_addr_i;
    logic [DATA_WIDTH-1:0] tag_data;
    logic                  pkt_ready;
    logic [LEN_WIDTH-1:0]  pkt_len;
    logic                  pkt_done;
    logic                  err_trunc;

    pkt_tag_buffer #(
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .tag_addr_i (tag_addr_i),
        .tag_data   (tag_data),
        .pkt_ready  (pkt_ready),
        .pkt_len    (pkt_len),
        .pkt_done   (pkt_done),
        .err_trunc  (err_trunc)
    );

    always #5 clk = ~clk;

    // Packet store: payloads by id, scoreboard holds ids in send order.
    logic [7:0] pkt_mem [N_PKT][MAX_PKT];
    int         plen_tab [N_PKT];
    int         next_id = 0;
    int         sb_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int make_pkt(input int len);
        int id;
        id = next_id % N_PKT;
        next_id++;
        plen_tab[id] = len;
        for (int i = 0; i < MAX_PKT; i++) begin
            pkt_mem[id][i] = (i < len) ? 8'($urandom) : 8'h00;
        end
        return id;
    endfunction

    function automatic logic [31:0] model_word(input int id, input logic [15:0] a);
        logic [31:0] w;
        int          stored;
        int          off;
        w      = 32'h0;
        stored = (plen_tab[id] < DEPTH) ? plen_tab[id] : DEPTH;
        for (int j = 0; j < 4; j++) begin
            off = int'(a) + j;
            if (off < stored) begin
                w[31-8*j -: 8] = pkt_mem[id][off];
            end
        end
        return w;
    endfunction

    task automatic wait_in_ready();
        int budget;
        budget = 0;
        while (!in_ready && budget < 300) begin
            tick();
            budget++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
    endtask

    // Sends packet 'id'; optionally raises pkt_done on the last-byte edge.
    task automatic send_pkt(input int id, input bit done_on_last);
        int len;
        len = plen_tab[id];
        sb_q.push_back(id);
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_data  = pkt_mem[id][i];
            in_last  = (i == len - 1);
            if (done_on_last && (i == len - 1)) pkt_done = 1'b1;
            wait_in_ready();
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (done_on_last) pkt_done = 1'b0;
        check("err_trunc_after_last", err_trunc, (len > DEPTH) ? 1 : 0);
        if (len > DEPTH) begin
            tick();
            check("err_trunc_one_pulse", err_trunc, 0);
        end
    endtask

    // Pops the oldest expected packet and checks what the DUT presents.
    task automatic consume_pkt();
        int budget;
        int id;
        int exp_len;
        int addrs [11];
        logic [15:0] a;
        budget = 0;
        while (!pkt_ready && budget < 500) begin
            tick();
            budget++;
        end
        check("pkt_ready", pkt_ready, 1);
        check("sb_nonempty", (sb_q.size() != 0) ? 1 : 0, 1);
        if (sb_q.size() == 0) return;
        id      = sb_q.pop_front();
        exp_len = (plen_tab[id] < DEPTH) ? plen_tab[id] : DEPTH;
        check("pkt_len", pkt_len, exp_len);
        addrs = '{0, 1, 2, 3, exp_len - 3, exp_len - 1, exp_len, DEPTH - 2, 300, 65534,
                  $urandom_range(0, exp_len + 3)};
        for (int k = 0; k < 11; k++) begin
            a          = 16'(addrs[k]);
            tag_addr_i = a;
            tick();
            check($sformatf("tag_data@%0d", a), tag_data, model_word(id, a));
        end
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0, p1, p2, p3, pa, pb, pp, pq, pr;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        tag_addr_i = '0;
        pkt_done   = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_pkt_ready", pkt_ready, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_tag_data", tag_data, 32'h0);
        check("rst_err_trunc", err_trunc, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // pkt_done with nothing presented is ignored
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
        check("idle_done_pkt_ready", pkt_ready, 0);
        check("idle_done_in_ready", in_ready, 1);
        p0 = make_pkt(8);
        send_pkt(p0, 1'b0);
        consume_pkt();

        // 60-byte frame with EtherType 0x0800 at offset 12
        p1 = make_pkt(60);
        pkt_mem[p1][12] = 8'h08;
        pkt_mem[p1][13] = 8'h00;
        send_pkt(p1, 1'b0);
        tag_addr_i = 16'd12;
        tick();
        check("ethertype", tag_data[31:16], 16'h0800);
        check("eth_pkt_len", pkt_len, 60);
        consume_pkt();

        // Three back-to-back 20-byte packets, both banks fill
        p1 = make_pkt(20);
        p2 = make_pkt(20);
        p3 = make_pkt(20);
        send_pkt(p1, 1'b0);
        send_pkt(p2, 1'b0);
        check("both_full_in_ready", in_ready, 0);
        fork
            send_pkt(p3, 1'b0);
            begin
                repeat (4) tick();
                check("stall_in_ready", in_ready, 0);
                consume_pkt();
            end
        join
        consume_pkt();
        consume_pkt();

        // Oversize packet truncates, following packet unaffected
        p1 = make_pkt(300);
        p2 = make_pkt(5);
        send_pkt(p1, 1'b0);
        send_pkt(p2, 1'b0);
        consume_pkt();
        consume_pkt();

        // One-byte packet
        p1 = make_pkt(1);
        send_pkt(p1, 1'b0);
        consume_pkt();

        // Release and completion on the same edge
        pa = make_pkt(24);
        pb = make_pkt(33);
        send_pkt(pa, 1'b0);
        check("a_len", pkt_len, 24);
        void'(sb_q.pop_front());
        send_pkt(pb, 1'b1);
        check("same_edge_pkt_ready", pkt_ready, 1);
        check("same_edge_pkt_len", pkt_len, 33);
        check("same_edge_in_ready", in_ready, 1);
        consume_pkt();

        // Reset with one bank full and a packet half written
        pp = make_pkt(30);
        send_pkt(pp, 1'b0);
        consume_pkt();
        pq = make_pkt(30);
        send_pkt(pq, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 8'hA0);
            in_last  = 1'b0;
            wait_in_ready();
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("mid_rst_in_ready", in_ready, 0);
        tick();
        check("mid_rst_pkt_ready", pkt_ready, 0);
        check("mid_rst_pkt_len", pkt_len, 0);
        check("mid_rst_tag_data", tag_data, 32'h0);
        rst = 1'b0;
        sb_q.delete();
        tick();
        check("rst_release_in_ready", in_ready, 1);
        check("rst_release_pkt_ready", pkt_ready, 0);
        pr = make_pkt(14);
        send_pkt(pr, 1'b0);
        consume_pkt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
